// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM capture path.
package pwm_pkg;

   typedef enum logic [1:0] {
      IDLE,
      HIGH,
      LOW
   } cap_state_t;

   // Duty code meaning 100 % for an r-bit resolution generator.
   function automatic int unsigned DUTY_FULL(input int unsigned r);
      return 32'd1 << r;
   endfunction

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing an (R+1)-bit duty quotient, one bit per cycle, MSB first.
module pwm_duty_div
   import pwm_pkg::*;
#(
   parameter int R     = 8,
   parameter int CNT_W = 32
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W+R-1:0] dividend,
   input  logic [CNT_W-1:0]   divisor,
   output logic               busy,
   output logic               done,
   output logic [R:0]         quotient
);

   localparam int IDX_W = $clog2(R + 1);

   logic             busy_q, busy_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [CNT_W:0]   rem_q, rem_d;
   logic [CNT_W-1:0] dsr_q, dsr_d;
   logic [R-1:0]     dlo_q, dlo_d;
   logic [R-1:0]     quo_q, quo_d;
   logic             ge;
   logic [CNT_W-1:0] diff;

   // Partial remainder stays below the divisor after each step, so CNT_W bits hold the difference.
   always_comb begin
      ge     = (rem_q >= {1'b0, dsr_q});
      diff   = ge ? (rem_q[CNT_W-1:0] - dsr_q) : rem_q[CNT_W-1:0];
      busy_d = busy_q;
      idx_d  = idx_q;
      rem_d  = rem_q;
      dsr_d  = dsr_q;
      dlo_d  = dlo_q;
      quo_d  = quo_q;
      if (abort) begin
         busy_d = 1'b0;
      end else if (busy_q) begin
         rem_d = {diff, dlo_q[R-1]};
         dlo_d = dlo_q << 1;
         quo_d = {quo_q[R-2:0], ge};
         idx_d = idx_q - IDX_W'(1);
         if (idx_q == '0) begin
            busy_d = 1'b0;
         end
      end else if (start) begin
         busy_d = 1'b1;
         idx_d  = IDX_W'(R);
         rem_d  = {1'b0, dividend[CNT_W+R-1:R]};
         dlo_d  = dividend[R-1:0];
         dsr_d  = divisor;
         quo_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         idx_q  <= '0;
      end else begin
         busy_q <= busy_d;
         idx_q  <= idx_d;
      end
   end

   always_ff @(posedge clk) begin
      rem_q <= rem_d;
      dsr_q <= dsr_d;
      dlo_q <= dlo_d;
      quo_q <= quo_d;
   end

   assign busy     = busy_q;
   assign done     = busy_q && (idx_q == '0) && !abort;
   assign quotient = {quo_q, ge};

endmodule

// File: rtl/pwm_capture.sv
// Measures an external PWM input: period, high time and duty in the generator's R+1-bit code,
// with stuck-input detection and a sticky overrun flag.
module pwm_capture
   import pwm_pkg::*;
#(
   parameter int R       = 8,
   parameter int CNT_W   = 32,
   parameter int TIMEOUT = 2_000_000
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             pwm_in,
   input  logic             clr_ovr,
   output logic [R:0]       duty,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time,
   output logic             valid,
   output logic             stuck_hi,
   output logic             stuck_lo,
   output logic             overrun
);

   localparam logic [R:0]       FULL    = (R+1)'(DUTY_FULL(R));
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT);

   logic             sync_q, pin_s_q, pin_p_q;
   cap_state_t       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
   logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
   logic [CNT_W-1:0] per_snap_q, per_snap_d;
   logic [CNT_W-1:0] hi_snap_q, hi_snap_d;
   logic [R:0]       duty_q, duty_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic [CNT_W-1:0] high_q, high_d;
   logic             valid_q, valid_d;
   logic             stuck_hi_q, stuck_hi_d;
   logic             stuck_lo_q, stuck_lo_d;
   logic             overrun_q, overrun_d;

   logic             rise, fall, edge_s, tmo, complete, div_start;
   logic             div_busy, div_done;
   logic [R:0]       div_quo;

   pwm_duty_div #(
      .R     (R),
      .CNT_W (CNT_W)
   ) u_div (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (div_start),
      .abort    (tmo),
      .dividend ({hi_cnt_q, {R{1'b0}}}),
      .divisor  (cnt_q),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   always_comb begin
      rise      = pin_s_q & ~pin_p_q;
      fall      = ~pin_s_q & pin_p_q;
      edge_s    = rise | fall;
      // An edge in the same cycle restarts the stuck counter instead of timing out.
      tmo       = ~edge_s && (to_cnt_q == TO_LAST);
      complete  = (state_q == LOW) && rise;
      div_start = complete && !div_busy;

      state_d = state_q;
      case (state_q)
         IDLE:    if (rise) state_d = HIGH;
         HIGH:    if (fall) state_d = LOW;
         LOW:     if (rise) state_d = HIGH;
         default: state_d = IDLE;
      endcase
      if (tmo) begin
         state_d = IDLE;
      end

      cnt_d      = rise ? CNT_W'(1) : cnt_q + CNT_W'(1);
      hi_cnt_d   = ((state_q == HIGH) && fall) ? cnt_q : hi_cnt_q;
      to_cnt_d   = edge_s ? CNT_W'(1) :
                   (to_cnt_q != TO_MAX) ? to_cnt_q + CNT_W'(1) : to_cnt_q;
      per_snap_d = div_start ? cnt_q : per_snap_q;
      hi_snap_d  = div_start ? hi_cnt_q : hi_snap_q;
      overrun_d  = (complete && div_busy) || (overrun_q && !clr_ovr);

      duty_d     = duty_q;
      period_d   = period_q;
      high_d     = high_q;
      stuck_hi_d = stuck_hi_q;
      stuck_lo_d = stuck_lo_q;
      valid_d    = 1'b0;
      if (tmo) begin
         duty_d     = pin_s_q ? FULL : '0;
         period_d   = '0;
         high_d     = '0;
         stuck_hi_d = pin_s_q;
         stuck_lo_d = ~pin_s_q;
         valid_d    = 1'b1;
      end else if (div_done) begin
         duty_d     = div_quo;
         period_d   = per_snap_q;
         high_d     = hi_snap_q;
         stuck_hi_d = 1'b0;
         stuck_lo_d = 1'b0;
         valid_d    = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q     <= 1'b0;
         pin_s_q    <= 1'b0;
         pin_p_q    <= 1'b0;
         state_q    <= IDLE;
         to_cnt_q   <= '0;
         duty_q     <= '0;
         period_q   <= '0;
         high_q     <= '0;
         valid_q    <= 1'b0;
         stuck_hi_q <= 1'b0;
         stuck_lo_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         sync_q     <= pwm_in;
         pin_s_q    <= sync_q;
         pin_p_q    <= pin_s_q;
         state_q    <= state_d;
         to_cnt_q   <= to_cnt_d;
         duty_q     <= duty_d;
         period_q   <= period_d;
         high_q     <= high_d;
         valid_q    <= valid_d;
         stuck_hi_q <= stuck_hi_d;
         stuck_lo_q <= stuck_lo_d;
         overrun_q  <= overrun_d;
      end
   end

   always_ff @(posedge clk) begin
      cnt_q      <= cnt_d;
      hi_cnt_q   <= hi_cnt_d;
      per_snap_q <= per_snap_d;
      hi_snap_q  <= hi_snap_d;
   end

   assign duty      = duty_q;
   assign period    = period_q;
   assign high_time = high_q;
   assign valid     = valid_q;
   assign stuck_hi  = stuck_hi_q;
   assign stuck_lo  = stuck_lo_q;
   assign overrun   = overrun_q;

endmodule
